// File: rtl/register_bank_pkg.sv
// Shared sizing constants and types for the register file, decoder and datapath.
// Pure declarations: no logic, no latency, no flow control.
package register_bank_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int REG_COUNT  = 8;
  localparam int SEL_WIDTH  = $clog2(REG_COUNT);

  typedef logic [SEL_WIDTH-1:0]  reg_sel_t;
  typedef logic [DATA_WIDTH-1:0] reg_data_t;
endpackage

// File: rtl/register_bank_if.sv
// Register file access bus: the control side drives selector/enables/write data,
// the register file returns registered read data. No handshake; every enabled cycle completes.
interface register_bank_if;
  import register_bank_pkg::*;

  reg_sel_t  in_selector;
  reg_data_t in_data;
  logic      write_en;
  logic      read_en;
  reg_data_t out_data;

  modport master (
    output in_selector,
    output in_data,
    output write_en,
    output read_en,
    input  out_data
  );

  modport slave (
    input  in_selector,
    input  in_data,
    input  write_en,
    input  read_en,
    output out_data
  );
endinterface

// File: rtl/register_bank_cell.sv
// Single WIDTH-bit storage register with load enable and async active-low clear.
// Loads on the enabling edge; no back-pressure.
module register_cell #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end
endmodule

// File: rtl/register_bank.sv
// Eight-entry register file: one write port and one registered read port sharing a selector.
// Write stores at the enabling edge, read data valid one cycle after read_en; never stalls.
module register_bank
  import register_bank_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  register_bank_if.slave  bus
);
  logic [REG_COUNT-1:0] wr_onehot;
  reg_data_t            regs [REG_COUNT];
  reg_data_t            rd_mux;
  reg_data_t            out_q;

  always_comb begin
    wr_onehot = '0;
    if (bus.write_en) begin
      wr_onehot[bus.in_selector] = 1'b1;
    end
  end

  for (genvar i = 0; i < REG_COUNT; i++) begin : g_cell
    register_cell #(
      .WIDTH (DATA_WIDTH)
    ) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (wr_onehot[i]),
      .d     (bus.in_data),
      .q     (regs[i])
    );
  end

  // Mux reads the cell outputs before the edge, so a same-index write returns old data.
  assign rd_mux = regs[bus.in_selector];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else if (bus.read_en) begin
      out_q <= rd_mux;
    end
  end

  assign bus.out_data = out_q;

  sel_known_a : assert property (
    @(posedge clk) disable iff (!rst_n)
    (bus.write_en || bus.read_en) |-> !$isunknown(bus.in_selector)
  );
endmodule

// File: tb/tb_register_bank.sv
// Directed plus random checks of register_bank against an array-based reference model.
module tb_register_bank;
  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  logic [7:0] mdl_regs [8];
  logic [7:0] mdl_out;

  register_bank_if bus ();

  register_bank dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mdl_regs[i] = 8'h00;
    mdl_out = 8'h00;
  endtask

  // Drive one cycle from a negedge, apply the access rules to the model, check out_data.
  task automatic step(input logic [2:0] sel, input logic [7:0] d,
                      input logic we, input logic re, input string tag);
    bus.in_selector = sel;
    bus.in_data     = d;
    bus.write_en    = we;
    bus.read_en     = re;
    @(posedge clk);
    if (rst_n) begin
      if (re) mdl_out = mdl_regs[sel];
      if (we) mdl_regs[sel] = d;
    end
    #1 check(tag, bus.out_data, mdl_out);
    @(negedge clk);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n           = 1'b0;
    bus.in_selector = '0;
    bus.in_data     = '0;
    bus.write_en    = 1'b0;
    bus.read_en     = 1'b0;
    model_reset();

    #2 check("reset_out", bus.out_data, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) step(3'(i), 8'h00, 1'b0, 1'b1, "post_reset_read");

    // Write then read
    step(3'd4, 8'hAA, 1'b1, 1'b0, "wr_r4");
    step(3'd0, 8'h0F, 1'b1, 1'b0, "wr_r0");
    step(3'd0, 8'h00, 1'b0, 1'b1, "rd_r0");
    check("rd_r0_const", bus.out_data, 8'h0F);
    step(3'd4, 8'h00, 1'b0, 1'b1, "rd_r4");
    check("rd_r4_const", bus.out_data, 8'hAA);

    // Hold with read disabled while other inputs wiggle
    step(3'd1, 8'h3C, 1'b0, 1'b0, "hold_a");
    step(3'd5, 8'($urandom), 1'b1, 1'b0, "hold_b");
    step(3'd7, 8'($urandom), 1'b1, 1'b0, "hold_c");
    check("hold_const", bus.out_data, 8'hAA);

    // Full sweep
    for (int i = 0; i < 8; i++) step(3'(i), 8'(8'h11 * i), 1'b1, 1'b0, "sweep_wr");
    for (int i = 0; i < 8; i++) begin
      step(3'(i), 8'hFF, 1'b0, 1'b1, "sweep_rd");
      check("sweep_rd_const", bus.out_data, 8'(8'h11 * i));
    end

    // Same-index collision returns old contents
    step(3'd2, 8'h33, 1'b1, 1'b0, "coll_wr");
    step(3'd2, 8'h5C, 1'b1, 1'b1, "coll_rw");
    check("coll_old_const", bus.out_data, 8'h33);
    step(3'd2, 8'h00, 1'b0, 1'b1, "coll_next");
    check("coll_new_const", bus.out_data, 8'h5C);

    // Reset between edges with a write pending
    step(3'd6, 8'h00, 1'b0, 1'b1, "pre_rst_rd");
    bus.in_selector = 3'd6;
    bus.in_data     = 8'h77;
    bus.write_en    = 1'b1;
    bus.read_en     = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1 check("async_reset_out", bus.out_data, 8'h00);
    @(posedge clk);
    #1 check("reset_held_out", bus.out_data, 8'h00);
    @(negedge clk);
    bus.write_en = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) step(3'(i), 8'h00, 1'b0, 1'b1, "post_midrst_read");

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      step(3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom), 1'($urandom), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
